// File: rtl/nios_system_leds_pkg.sv
// Shared constants for the LED output PIO: register word addresses, timer width
// and STATUS bit positions.
package nios_system_leds_pkg;

    localparam int unsigned PERIOD_W = 24;

    typedef enum logic [2:0] {
        ADDR_DATA         = 3'd0,
        ADDR_BLINK_EN     = 3'd1,
        ADDR_BLINK_PERIOD = 3'd2,
        ADDR_STATUS       = 3'd3,
        ADDR_OUTSET       = 3'd4,
        ADDR_OUTCLEAR     = 3'd5
    } reg_addr_e;

    localparam int unsigned STATUS_PHASE_BIT   = 0;
    localparam int unsigned STATUS_RUNNING_BIT = 1;

endpackage

// File: rtl/nios_system_leds_blink_timer.sv
// Blink phase generator: a down-counter that toggles phase every `period` cycles
// while `run` holds; `reload` restarts it from the supplied period with phase 0.
module nios_system_leds_blink_timer
    import nios_system_leds_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = 24'd2500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                run,
    input  logic                reload,
    output logic                phase,
    output logic                running
);

    logic [PERIOD_W-1:0] cnt_q;
    logic                phase_q;

    // Reload has priority over an expiry in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= PERIOD_RESET - PERIOD_W'(1);
            phase_q <= 1'b0;
        end else if (reload || !run) begin
            cnt_q   <= period - PERIOD_W'(1);
            phase_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q   <= period - PERIOD_W'(1);
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q - PERIOD_W'(1);
        end
    end

    assign phase   = phase_q;
    assign running = run;

endmodule

// File: rtl/nios_system_leds_out.sv
// Avalon-MM LED output port: DATA with set/clear aliases, registered read mux and
// LED drive. Blink engine present only when NIOS_SYSTEM_LEDS_BLINK_EN is defined.
module nios_system_leds_out
    import nios_system_leds_pkg::*;
#(
    parameter int unsigned         WIDTH        = 8,
    parameter logic [31:0]         RESET_VALUE  = '0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = 24'd2500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_mask;
    logic [31:0]      rd_d;

    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default:       ;
            endcase
        end
    end

`ifdef NIOS_SYSTEM_LEDS_BLINK_EN
    logic [WIDTH-1:0]    en_q, en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr;
    logic                run;
    logic                phase;
    logic                running;
    logic                unused_wd;

    assign unused_wd = ^writedata;

    always_comb begin
        en_d      = en_q;
        period_d  = period_q;
        period_wr = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_BLINK_EN: en_d = wd;
                ADDR_BLINK_PERIOD: begin
                    period_d  = writedata[PERIOD_W-1:0];
                    period_wr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign run = (period_q != '0) && (en_q != '0);

    // The timer sees the next-state period so a reload picks up the value being written.
    nios_system_leds_blink_timer #(
        .PERIOD_RESET(PERIOD_RESET)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .run     (run),
        .reload  (period_wr),
        .phase   (phase),
        .running (running)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= '0;
            period_q <= PERIOD_RESET;
        end else begin
            en_q     <= en_d;
            period_q <= period_d;
        end
    end

    assign blink_mask = en_q & {WIDTH{phase}};

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA:         rd_d[WIDTH-1:0]    = data_q;
            ADDR_BLINK_EN:     rd_d[WIDTH-1:0]    = en_q;
            ADDR_BLINK_PERIOD: rd_d[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                rd_d[STATUS_PHASE_BIT]   = phase;
                rd_d[STATUS_RUNNING_BIT] = running;
            end
            default: ;
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{writedata, PERIOD_RESET};
    assign blink_mask = '0;

    always_comb begin
        rd_d = '0;
        if (address == ADDR_DATA) begin
            rd_d[WIDTH-1:0] = data_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            readdata <= '0;
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q   <= data_d;
            readdata <= rd_d;
            out_port <= data_q & ~blink_mask;
        end
    end

endmodule
